// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side fields, register bank read data, writeback
// snoop, pipeline control and the registered execute-side fields.
interface id_ex_stage_if #(
    parameter int WIDTH     = 8,
    parameter int ADD_WIDTH = 5,
    parameter int OP_WIDTH  = 4
);
    logic                 id_valid;
    logic [OP_WIDTH-1:0]  id_op;
    logic [ADD_WIDTH-1:0] id_rs1;
    logic [ADD_WIDTH-1:0] id_rs2;
    logic                 id_use_rs2;
    logic [ADD_WIDTH-1:0] id_rd;
    logic                 id_wen;
    logic                 id_mem_read;
    logic [WIDTH-1:0]     id_imm;
    logic [WIDTH-1:0]     rd_data1;
    logic [WIDTH-1:0]     rd_data2;
    logic                 wb_en;
    logic [ADD_WIDTH-1:0] wb_reg;
    logic [WIDTH-1:0]     wb_data;
    logic                 flush;
    logic                 ex_hold;
    logic                 stall;
    logic                 ex_valid;
    logic [OP_WIDTH-1:0]  ex_op;
    logic [WIDTH-1:0]     ex_a;
    logic [WIDTH-1:0]     ex_b;
    logic [WIDTH-1:0]     ex_imm;
    logic [ADD_WIDTH-1:0] ex_rd;
    logic                 ex_wen;
    logic                 ex_mem_read;
    logic [7:0]           stall_cnt;

    modport master (
        output id_valid, id_op, id_rs1, id_rs2, id_use_rs2, id_rd, id_wen,
               id_mem_read, id_imm, rd_data1, rd_data2, wb_en, wb_reg, wb_data,
               flush, ex_hold,
        input  stall, ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_rd, ex_wen,
               ex_mem_read, stall_cnt
    );

    modport slave (
        input  id_valid, id_op, id_rs1, id_rs2, id_use_rs2, id_rd, id_wen,
               id_mem_read, id_imm, rd_data1, rd_data2, wb_en, wb_reg, wb_data,
               flush, ex_hold,
        output stall, ex_valid, ex_op, ex_a, ex_b, ex_imm, ex_rd, ex_wen,
               ex_mem_read, stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush/hold handling and a saturating hazard-stall counter.
module id_ex_stage #(
    parameter int WIDTH     = 8,
    parameter int ADD_WIDTH = 5,
    parameter int OP_WIDTH  = 4
) (
    input logic           clk,
    input logic           rst_n,
    id_ex_stage_if.slave  bus
);
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 haz;

    logic                 valid_q;
    logic [OP_WIDTH-1:0]  op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     imm_q;
    logic [ADD_WIDTH-1:0] rd_q;
    logic                 wen_q;
    logic                 mem_read_q;
    logic [7:0]           cnt_q;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    always_comb begin
        op_a = bus.rd_data1;
        op_b = bus.rd_data2;
        if (bus.wb_en && bus.wb_reg != '0 && bus.wb_reg == bus.id_rs1)
            op_a = bus.wb_data;
        if (bus.wb_en && bus.wb_reg != '0 && bus.wb_reg == bus.id_rs2)
            op_b = bus.wb_data;
    end

    always_comb begin
        haz = bus.id_valid && valid_q && mem_read_q && rd_q != '0 &&
              (rd_q == bus.id_rs1 || (bus.id_use_rs2 && rd_q == bus.id_rs2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            mem_read_q <= 1'b0;
            cnt_q      <= '0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
            wen_q      <= 1'b0;
            mem_read_q <= 1'b0;
        end else if (bus.ex_hold) begin
            valid_q    <= valid_q;
        end else if (haz) begin
            // Bubble: only the control bits are cleared; data fields are don't-care.
            valid_q    <= 1'b0;
            wen_q      <= 1'b0;
            mem_read_q <= 1'b0;
            if (cnt_q != '1)
                cnt_q <= cnt_q + 8'd1;
        end else begin
            valid_q    <= bus.id_valid;
            op_q       <= bus.id_op;
            a_q        <= op_a;
            b_q        <= op_b;
            imm_q      <= bus.id_imm;
            rd_q       <= bus.id_rd;
            wen_q      <= bus.id_valid && bus.id_wen;
            mem_read_q <= bus.id_valid && bus.id_mem_read;
        end
    end

    assign bus.stall       = rst_n && (haz || bus.ex_hold);
    assign bus.ex_valid    = valid_q;
    assign bus.ex_op       = op_q;
    assign bus.ex_a        = a_q;
    assign bus.ex_b        = b_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_rd       = rd_q;
    assign bus.ex_wen      = wen_q;
    assign bus.ex_mem_read = mem_read_q;
    assign bus.stall_cnt   = cnt_q;
endmodule
